// File: rtl/mc_rv_cpu.sv
// mc_rv_cpu: multi-cycle RV32-subset core sharing one memory port for fetch and data
package mc_rv_pkg;
    typedef enum logic [1:0] {SIZE_BYTE = 2'd0, SIZE_WORD = 2'd2} access_size_t;
endpackage

module mc_rv_cpu
    import mc_rv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_data_valid_i,
    input  logic                  mem_data_is_instr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  rd_req_valid_o,
    output logic                  wr_req_valid_o,
    output logic                  req_is_instr_o,
    output logic [ADDR_WIDTH-1:0] req_address_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output access_size_t          req_access_size_o,
    output logic                  debug_instr_is_completed_o,
    output logic [DATA_WIDTH-1:0] debug_regs_o [32],
    output logic [ADDR_WIDTH-1:0] debug_pc_o,
    output logic [31:0]           debug_instr_o
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    localparam logic [6:0] OP_R = 7'h33, OP_LD = 7'h03, OP_ST = 7'h23, OP_BR = 7'h63, OP_JAL = 7'h6f;
    localparam logic [ADDR_WIDTH-1:0] PC_MASK = ADDR_WIDTH'(MEM_SIZE - 1);

    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] pc, npc, mar, pc_nx;
    logic [31:0] ir;
    logic [DATA_WIDTH-1:0] a, b, imm, imm_d, alu;
    logic [DATA_WIDTH-1:0] regs [32];
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic is_r, is_ld, is_st, br_ok, take, fetch_done, mem_done;

    assign op = ir[6:0];
    assign f3 = ir[14:12];
    assign f7 = ir[31:25];
    assign rd = ir[11:7];
    assign fetch_done = mem_data_valid_i && mem_data_is_instr_i;
    assign mem_done = mem_data_valid_i && !mem_data_is_instr_i;
    assign is_r = op == OP_R && f3 == 3'b000 && (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01);
    assign is_ld = op == OP_LD && (f3 == 3'b000 || f3 == 3'b010);
    assign is_st = op == OP_ST && (f3 == 3'b000 || f3 == 3'b010);
    assign br_ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
    assign take = f3 == 3'd0 ? a == b : f3 == 3'd1 ? a != b : f3 == 3'd4 ? a < b : a >= b;
    assign alu = f7 == 7'h20 ? a - b : f7 == 7'h01 ? a * b : a + b;
    // unsupported branch funct3 holds the PC so the instruction re-executes
    assign pc_nx = op == OP_JAL ? pc + ADDR_WIDTH'(imm)
                 : op == OP_BR ? (br_ok ? ((take ? pc + ADDR_WIDTH'(imm) : pc + ADDR_WIDTH'(4)) & PC_MASK) : pc)
                 : (pc + ADDR_WIDTH'(4)) & PC_MASK;

    always_comb begin
        imm_d = op == OP_ST ? DATA_WIDTH'({{20{ir[31]}}, ir[31:25], ir[11:7]})
              : op == OP_BR ? DATA_WIDTH'({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0})
              : op == OP_JAL ? DATA_WIDTH'({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0})
              : DATA_WIDTH'({{20{ir[31]}}, ir[31:20]});
    end

    always_ff @(posedge clk_i) begin
        state <= rst_i ? FETCH : state_nx;
    end

    always_comb begin
        state_nx = state == FETCH ? (fetch_done ? DECODE : FETCH)
                 : state == DECODE ? EXEC
                 : state == EXEC ? ((is_ld || is_st) ? MEM : WB)
                 : state == MEM ? (mem_done ? WB : MEM)
                 : FETCH;
    end

    always_comb begin
        rd_req_valid_o = !rst_i && (state == FETCH || (state == MEM && is_ld));
        wr_req_valid_o = !rst_i && state == MEM && is_st;
        req_is_instr_o = !rst_i && state == FETCH;
        req_address_o = rst_i ? '0 : state == FETCH ? pc : state == MEM ? mar : '0;
        wr_data_o = wr_req_valid_o ? (f3 == 3'b000 ? DATA_WIDTH'(b[7:0]) : b) : '0;
        req_access_size_o = (rd_req_valid_o || wr_req_valid_o) && (state == FETCH || f3 == 3'b010) ? SIZE_WORD : SIZE_BYTE;
        debug_instr_is_completed_o = !rst_i && state == WB;
    end

    // register writes land on the edge into WB so the commit cycle already shows them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc <= '0;
            npc <= '0;
            mar <= '0;
            ir <= '0;
            a <= '0;
            b <= '0;
            imm <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            if (state == FETCH && fetch_done) ir <= 32'(mem_data_i);
            if (state == DECODE) begin
                a <= regs[ir[19:15]];
                b <= regs[ir[24:20]];
                imm <= imm_d;
            end
            if (state == EXEC) begin
                npc <= pc_nx;
                mar <= ADDR_WIDTH'(a + imm);
                if (is_r) regs[rd] <= alu;
                if (op == OP_JAL) regs[rd] <= DATA_WIDTH'(pc + ADDR_WIDTH'(4));
            end
            if (state == MEM && mem_done && is_ld) regs[rd] <= f3 == 3'b000 ? DATA_WIDTH'(mem_data_i[7:0]) : mem_data_i;
            if (state == WB) pc <= npc;
        end
    end

    assign debug_regs_o = regs;
    assign debug_pc_o = pc;
    assign debug_instr_o = ir;
endmodule

// File: tb/tb_mc_rv_cpu.sv
// tb_mc_rv_cpu: directed program run against a variable-latency byte memory
module tb_mc_rv_cpu;
    import mc_rv_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] val;
        int          lat;
        bit          st;
    } vec_t;

    logic clk = 0, rst = 1;
    logic vld = 0, isi = 0;
    logic [31:0] rdata = '0;
    logic rd_req, wr_req, is_instr, commit;
    logic [31:0] req_addr, wr_data, dpc, dinstr;
    logic [31:0] dregs [32];
    access_size_t size;

    logic [7:0] mem [4096];
    logic [7:0] smem [4096];
    bit swr [4096];
    logic [11:0] ma;
    int lat = 4, cnt = 0, st_cnt = 0;
    logic [31:0] st_addr = '0, st_data = '0;
    access_size_t st_size = SIZE_WORD;
    bit both = 0;
    int n = 0, fails = 0;
    vec_t v [16];

    always #5 clk = ~clk;

    mc_rv_cpu dut (
        .clk_i(clk), .rst_i(rst),
        .mem_data_valid_i(vld), .mem_data_is_instr_i(isi), .mem_data_i(rdata),
        .rd_req_valid_o(rd_req), .wr_req_valid_o(wr_req), .req_is_instr_o(is_instr),
        .req_address_o(req_addr), .wr_data_o(wr_data), .req_access_size_o(size),
        .debug_instr_is_completed_o(commit), .debug_regs_o(dregs),
        .debug_pc_o(dpc), .debug_instr_o(dinstr)
    );

    function automatic logic [7:0] byte_at(input logic [11:0] x);
        return swr[x] ? smem[x] : mem[x];
    endfunction

    assign ma = req_addr[11:0];

    always @(posedge clk) begin
        if (rd_req && wr_req) both <= 1;
        if (rst || vld) begin
            vld <= 0;
            cnt <= 0;
        end else if (rd_req || wr_req) begin
            if (cnt >= lat - 1) begin
                vld <= 1;
                isi <= is_instr;
                cnt <= 0;
                if (wr_req) begin
                    smem[ma] <= wr_data[7:0];
                    swr[ma] <= 1;
                    if (size == SIZE_WORD) begin
                        smem[ma + 12'd1] <= wr_data[15:8];
                        smem[ma + 12'd2] <= wr_data[23:16];
                        smem[ma + 12'd3] <= wr_data[31:24];
                        swr[ma + 12'd1] <= 1;
                        swr[ma + 12'd2] <= 1;
                        swr[ma + 12'd3] <= 1;
                    end
                    st_addr <= req_addr;
                    st_data <= wr_data;
                    st_size <= size;
                    st_cnt <= st_cnt + 1;
                    rdata <= '0;
                end else begin
                    rdata <= size == SIZE_WORD
                           ? {byte_at(ma + 12'd3), byte_at(ma + 12'd2), byte_at(ma + 12'd1), byte_at(ma)}
                           : {24'hA5A5A5, byte_at(ma)};
                end
            end else cnt <= cnt + 1;
        end
    end

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    function automatic logic [31:0] i_t(input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {im, rs1, f3, rd, 7'h03};
    endfunction
    function automatic logic [31:0] s_t(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {im[11:5], rs2, rs1, f3, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input logic [12:0] im, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
    endfunction

    task automatic put_word(input logic [11:0] a, input logic [31:0] w);
        mem[a] = w[7:0];
        mem[a + 12'd1] = w[15:8];
        mem[a + 12'd2] = w[23:16];
        mem[a + 12'd3] = w[31:24];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic commit_check(input string name, input logic [31:0] e_pc, input logic [31:0] e_ins, input logic [4:0] r, input logic [31:0] e_val);
        bit got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = commit;
        end
        n++;
        if (!got) begin
            fails++;
            $display("FAIL %s: no commit within 300 cycles, expected pc %h", name, e_pc);
            return;
        end
        if (dpc !== e_pc || dinstr !== e_ins || dregs[r] !== e_val) begin
            fails++;
            $display("FAIL %s: pc %h instr %h x%0d=%h, expected pc %h instr %h x%0d=%h",
                     name, dpc, dinstr, r, dregs[r], e_pc, e_ins, r, e_val);
        end
        @(negedge clk);
        check({name, "_pulse"}, {31'b0, commit}, 32'd0);
    endtask

    initial begin
        logic [31:0] binv, jal4, add14;
        binv = b_t(13'd8, 5'd0, 5'd0, 3'b010);
        jal4 = j_t(21'h00FA8, 5'd4);
        add14 = r_t(7'h00, 5'd6, 5'd6, 5'd14);
        v[0]  = '{32'h000, 32'h10002283,                       5'd5,  32'hDEADBEEF, 1, 1'b0};
        v[1]  = '{32'h004, i_t(12'h101, 5'd0, 3'b000, 5'd6),   5'd6,  32'h000000BE, 2, 1'b0};
        v[2]  = '{32'h008, r_t(7'h01, 5'd6, 5'd6, 5'd8),       5'd8,  32'h00008D04, 1, 1'b0};
        v[3]  = '{32'h00C, r_t(7'h20, 5'd5, 5'd0, 5'd7),       5'd7,  32'h21524111, 3, 1'b0};
        v[4]  = '{32'h010, r_t(7'h00, 5'd7, 5'd5, 5'd9),       5'd9,  32'h00000000, 1, 1'b0};
        v[5]  = '{32'h014, s_t(12'h200, 5'd5, 5'd0, 3'b000),   5'd5,  32'hDEADBEEF, 2, 1'b1};
        v[6]  = '{32'h018, i_t(12'h200, 5'd0, 3'b010, 5'd10),  5'd10, 32'h000000EF, 1, 1'b0};
        v[7]  = '{32'h01C, b_t(13'd16, 5'd5, 5'd6, 3'b100),    5'd6,  32'h000000BE, 1, 1'b0};
        v[8]  = '{32'h02C, b_t(13'd16, 5'd5, 5'd6, 3'b101),    5'd6,  32'h000000BE, 4, 1'b0};
        v[9]  = '{32'h030, b_t(13'd8, 5'd1, 5'd1, 3'b001),     5'd1,  32'h00000000, 1, 1'b0};
        v[10] = '{32'h034, r_t(7'h00, 5'd5, 5'd5, 5'd0),       5'd0,  32'hBD5B7DDE, 1, 1'b0};
        v[11] = '{32'h038, b_t(13'd8, 5'd1, 5'd1, 3'b000),     5'd1,  32'h00000000, 2, 1'b0};
        v[12] = '{32'h040, j_t(21'd8, 5'd1),                   5'd1,  32'h00000044, 1, 1'b0};
        v[13] = '{32'h048, j_t(21'h00FB0, 5'd3),               5'd3,  32'h0000004C, 1, 1'b0};
        v[14] = '{32'hFF8, b_t(13'h054, 5'd1, 5'd1, 3'b000),   5'd1,  32'h00000044, 1, 1'b0};
        v[15] = '{32'h04C, r_t(7'h20, 5'd0, 5'd0, 5'd0),       5'd0,  32'h00000000, 1, 1'b0};
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        put_word(12'h100, 32'hDEADBEEF);
        for (int i = 0; i < 16; i++) put_word(v[i].pc[11:0], v[i].instr);
        put_word(12'h050, binv);
        put_word(12'h054, jal4);
        put_word(12'hFFC, add14);

        repeat (3) @(negedge clk);
        check("rst_rd_req", {31'b0, rd_req}, 32'd0);
        check("rst_commit", {31'b0, commit}, 32'd0);
        check("rst_pc", dpc, 32'd0);
        check("rst_x5", dregs[5], 32'd0);
        rst = 0;
        #1;
        check("first_fetch", {rd_req, is_instr, size == SIZE_WORD, req_addr[28:0]}, {3'b111, 29'd0});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("fetch_hold", {commit, rd_req, req_addr[29:0]}, {2'b01, 30'd0});
        end

        for (int i = 0; i < 16; i++) begin
            lat = v[i].lat;
            commit_check($sformatf("vec%0d", i), v[i].pc, v[i].instr, v[i].rd, v[i].val);
            if (v[i].st) begin
                check("sb_count", st_cnt, 1);
                check("sb_addr", st_addr, 32'h200);
                check("sb_byte", {24'd0, st_data[7:0]}, 32'hEF);
                check("sb_size", {30'd0, st_size}, {30'd0, SIZE_BYTE});
            end
        end

        lat = 2;
        commit_check("br_bad1", 32'h050, binv, 5'd0, 32'd0);
        commit_check("br_bad2", 32'h050, binv, 5'd0, 32'd0);
        put_word(12'h050, 32'h00000FFF);
        commit_check("unknown_op", 32'h050, 32'h00000FFF, 5'd31, 32'd0);
        commit_check("jal_far", 32'h054, jal4, 5'd4, 32'h58);
        commit_check("seq_wrap", 32'hFFC, add14, 5'd14, 32'h17C);
        commit_check("wrap_to_0", 32'h000, 32'h10002283, 5'd5, 32'hDEADBEEF);

        lat = 20;
        repeat (3) @(negedge clk);
        check("pend_fetch", {rd_req, req_addr[30:0]}, {1'b1, 31'h4});
        rst = 1;
        @(negedge clk);
        check("mid_rst", {commit, rd_req, 30'd0}, 32'd0);
        check("mid_rst_x14", dregs[14], 32'd0);
        rst = 0;
        #1;
        check("refetch_0", {rd_req, req_addr[30:0]}, {1'b1, 31'h0});
        lat = 1;
        commit_check("after_rst", 32'h000, 32'h10002283, 5'd5, 32'hDEADBEEF);
        check("no_dual_req", {31'b0, both}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end
endmodule
